alu_addsub_seq: RTL and testbench

Parametrised, multi-cycle integer add/subtract unit with valid/ready handshakes and condition flags. It is the sequential successor to the combinational 32-bit `alu_add`. It resolves the carry chain CHUNK bits per cycle, which trades latency for a short critical path. It sits between the execute-stage issue logic and the writeback mux, and the same instance serves both add and sub.

---
 rtl/alu_addsub_seq_if.sv | 31 +++
 rtl/alu_addsub_seq.sv | 154 +++++++++++++++
 tb/tb_alu_addsub_seq.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/alu_addsub_seq_if.sv
// Operand/result bundle for alu_addsub_seq: request channel (rs1/rs2/op) and
// response channel (rd + condition flags), each with its own valid/ready pair.
interface alu_addsub_seq_if #(
    parameter int WIDTH = 32
);
    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high. A producer holds valid and its payload stable until that edge,
    // and valid never drops without a transfer. Ready may change freely.
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic [WIDTH-1:0] rs1;
    logic [WIDTH-1:0] rs2;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] rd;
    logic             flag_c;
    logic             flag_v;
    logic             flag_z;
    logic             flag_n;

    modport master (
        output in_valid, op, rs1, rs2, out_ready,
        input  in_ready, out_valid, rd, flag_c, flag_v, flag_z, flag_n
    );

    modport slave (
        input  in_valid, op, rs1, rs2, out_ready,
        output in_ready, out_valid, rd, flag_c, flag_v, flag_z, flag_n
    );
endinterface

// File: rtl/alu_addsub_seq.sv
// Multi-cycle add/sub resolving CHUNK bits of the carry chain per cycle.
// Optional clamp on signed overflow when built with ALU_ADDSUB_SAT_EN.
module alu_addsub_seq #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_addsub_seq_if.slave    bus,
    output logic [1:0]         dbg_state
);
    localparam int NSLICE = WIDTH / CHUNK;
    localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NSLICE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] rd_q;
    logic             carry_q;
    logic [KW-1:0]    k_q;
    logic             flag_c_q;
    logic             flag_v_q;
    logic             flag_z_q;
    logic             flag_n_q;

    logic             accept;
    logic             last;
    logic [CHUNK-1:0] a_sl;
    logic [CHUNK-1:0] b_sl;
    logic [CHUNK:0]   sl_sum;
    logic [WIDTH-1:0] full_rd;
    logic [WIDTH-1:0] final_rd;
    logic             msb_cin;
    logic             ovf;

`ifdef ALU_ADDSUB_SAT_EN
    logic             sat_q;
`else
    logic             unused_op1;
    assign unused_op1 = bus.op[1];
`endif

    assign accept = bus.in_valid & bus.in_ready;
    assign last   = (state_q == BUSY) && (k_q == K_LAST);

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = BUSY;
            BUSY: if (last) state_d = DONE;
            DONE: if (bus.out_ready) state_d = accept ? BUSY : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- output logic ----------------
    // DONE forwards out_ready to in_ready so a new request can overlap the drain.
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state_q)
            IDLE: bus.in_ready = 1'b1;
            DONE: begin
                bus.out_valid = 1'b1;
                bus.in_ready  = bus.out_ready;
            end
            default: ;
        endcase
    end

    assign dbg_state  = state_q;
    assign bus.rd     = rd_q;
    assign bus.flag_c = flag_c_q;
    assign bus.flag_v = flag_v_q;
    assign bus.flag_z = flag_z_q;
    assign bus.flag_n = flag_n_q;

    // ---------------- slice adder ----------------
    assign a_sl   = a_q[k_q*CHUNK +: CHUNK];
    assign b_sl   = b_q[k_q*CHUNK +: CHUNK];
    assign sl_sum = {1'b0, a_sl} + {1'b0, b_sl} + {{CHUNK{1'b0}}, carry_q};

    // Carry into the MSB is recovered from the sum bit, so no CHUNK-1 split is needed.
    always_comb begin
        full_rd = rd_q;
        full_rd[k_q*CHUNK +: CHUNK] = sl_sum[CHUNK-1:0];
        msb_cin  = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ full_rd[WIDTH-1];
        ovf      = sl_sum[CHUNK] ^ msb_cin;
        final_rd = full_rd;
`ifdef ALU_ADDSUB_SAT_EN
        if (sat_q && ovf) begin
            final_rd = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                    : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            rd_q     <= '0;
            carry_q  <= 1'b0;
            k_q      <= '0;
            flag_c_q <= 1'b0;
            flag_v_q <= 1'b0;
            flag_z_q <= 1'b0;
            flag_n_q <= 1'b0;
`ifdef ALU_ADDSUB_SAT_EN
            sat_q    <= 1'b0;
`endif
        end else if (accept) begin
            a_q     <= bus.rs1;
            b_q     <= bus.op[0] ? ~bus.rs2 : bus.rs2;
            carry_q <= bus.op[0];
            k_q     <= '0;
`ifdef ALU_ADDSUB_SAT_EN
            sat_q   <= bus.op[1];
`endif
        end else if (state_q == BUSY) begin
            carry_q <= sl_sum[CHUNK];
            k_q     <= k_q + KW'(1);
            if (last) begin
                rd_q     <= final_rd;
                flag_c_q <= sl_sum[CHUNK];
                flag_v_q <= ovf;
                flag_z_q <= (final_rd == '0);
                flag_n_q <= final_rd[WIDTH-1];
            end else begin
                rd_q     <= full_rd;
            end
        end
    end
endmodule

// File: tb/tb_alu_addsub_seq.sv
// Directed bench for alu_addsub_seq (WIDTH=32, CHUNK=8): latency, flags,
// saturation, backpressure with overlap, and mid-operation reset.
module tb_alu_addsub_seq;
    localparam int W = 32;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] dbg_state;

    logic [35:0] exp_q[$];
    int          n_checks = 0;
    int          n_bad    = 0;

    alu_addsub_seq_if #(.WIDTH(W)) bus ();

    alu_addsub_seq #(.WIDTH(W), .CHUNK(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] flags_now();
        return {bus.flag_c, bus.flag_v, bus.flag_z, bus.flag_n};
    endfunction

    // ---------------- driver tasks ----------------
    // Presents one request, pushes its expected {flags, rd}, returns at the
    // negedge right after the accept edge with junk on the operand lines.
    task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_rd, input logic [3:0] exp_f);
        int n;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op       = op;
        bus.rs1      = a;
        bus.rs2      = b;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("accept_timeout", 64'd0, 64'd1);
        exp_q.push_back({exp_f, exp_rd});
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.op       = 2'($urandom_range(0, 3));
        bus.rs1      = $urandom;
        bus.rs2      = $urandom;
    endtask

    // Counts edges since accept until out_valid; called at the first negedge after accept.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        if (!bus.out_valid) check("valid_timeout", 64'd0, 64'd1);
    endtask

    task automatic compare_head(input string tag);
        logic [35:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_noexp"}, 64'd0, 64'd1);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_rd"}, bus.rd, e[31:0]);
            check({tag, "_flags"}, flags_now(), e[35:32]);
        end
    endtask

    task automatic consume();
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic run(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_rd, input logic [3:0] exp_f);
        int lat;
        send(op, a, b, exp_rd, exp_f);
        wait_valid(lat);
        check({tag, "_lat"}, lat, 64'd4);
        compare_head(tag);
        consume();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lat;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.op        = 2'b00;
        bus.rs1       = '0;
        bus.rs2       = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", bus.in_ready, 64'd1);
        check("rst_out_valid", bus.out_valid, 64'd0);
        check("rst_rd", bus.rd, 64'd0);
        check("rst_flags", flags_now(), 64'd0);
        check("rst_state", dbg_state, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_in_ready", bus.in_ready, 64'd1);

        // flags are {c, v, z, n}
        run("add_1_1",     2'b00, 32'd1,        32'd1,        32'd2,        4'b0000);
        run("sub_10_10",   2'b01, 32'd10,       32'd10,       32'd0,        4'b1010);
        run("sub_10_m10",  2'b01, 32'd10,       32'hFFFF_FFF6, 32'd20,      4'b0000);
        run("add_wrap",    2'b00, 32'hFFFF_FFFF, 32'd2,        32'd1,        4'b1000);
        run("add_ovf",     2'b00, 32'h7FFF_FFFF, 32'd1,        32'h8000_0000, 4'b0101);
`ifdef ALU_ADDSUB_SAT_EN
        run("add_sat",     2'b10, 32'h7FFF_FFFF, 32'd1,        32'h7FFF_FFFF, 4'b0100);
        run("sub_sat",     2'b11, 32'h8000_0000, 32'd1,        32'h8000_0000, 4'b1101);
`else
        run("add_nosat",   2'b10, 32'h7FFF_FFFF, 32'd1,        32'h8000_0000, 4'b0101);
        run("sub_nosat",   2'b11, 32'h8000_0000, 32'd1,        32'h7FFF_FFFF, 4'b1100);
`endif
        run("sub_3_5",     2'b01, 32'd3,        32'd5,        32'hFFFF_FFFE, 4'b0001);
        run("add_chunkc",  2'b00, 32'h0000_FFFF, 32'h00FF_0001, 32'h0100_0000, 4'b0000);

        // Backpressure: hold the result for 3 cycles, then drain + accept together.
        send(2'b00, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 4'b0000);
        wait_valid(lat);
        check("bp_lat", lat, 64'd4);
        for (int i = 0; i < 3; i++) begin
            check("bp_hold_rd", bus.rd, 64'h2345_6789);
            check("bp_hold_flags", flags_now(), 64'd0);
            check("bp_hold_valid", bus.out_valid, 64'd1);
            check("bp_in_ready", bus.in_ready, 64'd0);
            @(negedge clk);
        end
        compare_head("bp_first");
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.op        = 2'b00;
        bus.rs1       = 32'd5;
        bus.rs2       = 32'd6;
        exp_q.push_back({4'b0000, 32'd11});
        #1;
        check("bp_overlap_ready", bus.in_ready, 64'd1);
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        bus.rs1       = $urandom;
        bus.rs2       = $urandom;
        check("bp_busy_state", dbg_state, 64'd1);
        wait_valid(lat);
        check("bp_second_lat", lat, 64'd4);
        compare_head("bp_second");
        consume();

        // Reset two cycles into the operation: everything returns to reset values.
        send(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 4'b1001);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_rd", bus.rd, 64'd0);
        check("mid_rst_flags", flags_now(), 64'd0);
        check("mid_rst_valid", bus.out_valid, 64'd0);
        check("mid_rst_in_ready", bus.in_ready, 64'd1);
        check("mid_rst_state", dbg_state, 64'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("no_stale_valid", bus.out_valid, 64'd0);
        end
        run("post_rst_zero", 2'b00, 32'd0, 32'd0, 32'd0, 4'b0010);

        check("queue_empty", exp_q.size(), 64'd0);
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end
endmodule
